qpsk_tx_sequencer: RTL and testbench

Single-clock controller that sequences the QPSK raised-cosine filter datapath.
- Accepts a serial bit stream over a valid/ready handshake and packs BIT_SYM bits into one symbol.
- Generates the per-sample phase counter and a one-cycle symbol strobe, which the filter and tap delay lines use as enables.
- Manages start, stop and tap-line flush, so the filter output rings down cleanly before going idle.

---
 rtl/qpsk_tx_pkg.sv | 25 ++
 rtl/qpsk_bit_packer.sv | 59 +++++
 rtl/qpsk_tx_sequencer.sv | 170 +++++++++++++++++
 tb/tb_qpsk_tx_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_tx_pkg.sv
// Shared definitions for the QPSK transmit sequencer: FSM encoding,
// fill-symbol default and the I/Q bit order inside a symbol.
package qpsk_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int unsigned IDLE_SYM_DEFAULT = 0;

    // First serial bit of a symbol is I, second is Q.
    localparam int unsigned BIT_I = 0;
    localparam int unsigned BIT_Q = 1;

    function automatic logic [1:0] iq_pack(input logic i_val, input logic q_val);
        logic [1:0] sym;
        sym        = 2'b00;
        sym[BIT_I] = i_val;
        sym[BIT_Q] = q_val;
        return sym;
    endfunction

endpackage

// File: rtl/qpsk_bit_packer.sv
// Serial-to-symbol packer: collects BIT_SYM bits, lowest slot first, and
// exposes a bypass view that includes a bit accepted on the current edge.
module qpsk_bit_packer
    import qpsk_tx_pkg::*;
#(
    parameter int unsigned BIT_SYM = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_discard,
    input  logic               i_take,
    input  logic               i_bit,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_complete,
    output logic [BIT_SYM-1:0] o_symbol
);

    localparam int unsigned FILL_W = $clog2(BIT_SYM + 1);

    logic [FILL_W-1:0]  r_fill;
    logic [BIT_SYM-1:0] r_bits;
    logic               w_accept;
    logic [FILL_W-1:0]  w_fill_next;
    logic [BIT_SYM-1:0] w_bits_next;

    assign o_ready     = i_enable && (r_fill < FILL_W'(BIT_SYM));
    assign w_accept    = i_valid && o_ready;
    assign w_fill_next = r_fill + FILL_W'(w_accept);

    genvar gi;
    generate
        for (gi = 0; gi < BIT_SYM; gi++) begin : g_slot
            assign w_bits_next[gi] = (w_accept && (r_fill == FILL_W'(gi))) ? i_bit : r_bits[gi];
        end
    endgenerate

    // Completion counts a bit arriving on this very edge, so a boundary can
    // consume it without a one-symbol underflow.
    assign o_complete = (w_fill_next == FILL_W'(BIT_SYM));
    assign o_symbol   = w_bits_next;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_fill <= '0;
            r_bits <= '0;
        end else if (i_discard) begin
            r_fill <= '0;
        end else if (i_take && o_complete) begin
            r_fill <= '0;
            r_bits <= w_bits_next;
        end else begin
            r_fill <= w_fill_next;
            r_bits <= w_bits_next;
        end
    end

endmodule

// File: rtl/qpsk_tx_sequencer.sv
// Sequencer for the QPSK raised-cosine transmit path: sample phase counter,
// symbol strobe, bit packing, and a tap-line flush before returning idle.
module qpsk_tx_sequencer
    import qpsk_tx_pkg::*;
#(
    parameter int unsigned       SPS       = 8,
    parameter int unsigned       SPAN      = 16,
    parameter int unsigned       BIT_SYM   = 2,
    parameter int unsigned       FLUSH_SYM = SPAN + 1,
    parameter logic [BIT_SYM-1:0] IDLE_SYM = BIT_SYM'(IDLE_SYM_DEFAULT)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_bit_in,
    input  logic                    i_bit_valid,
    output logic                    o_bit_ready,
    output logic [$clog2(SPS)-1:0]  o_count,
    output logic [BIT_SYM-1:0]      o_symbol,
    output logic                    o_sym_strobe,
    output logic                    o_busy,
    output logic                    o_underflow,
    output logic                    o_done
);

    localparam int unsigned CNT_W = $clog2(SPS);
    localparam int unsigned FL_W  = $clog2(FLUSH_SYM + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [BIT_SYM-1:0] r_symbol;
    logic               r_sym_strobe;
    logic               r_underflow;
    logic               r_done;
    logic               r_stop_latch;
    logic [FL_W-1:0]    r_flush_cnt;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_count_next;
    logic [BIT_SYM-1:0] w_symbol_next;
    logic               w_strobe_next;
    logic               w_underflow_next;
    logic               w_done_next;
    logic               w_stop_next;
    logic [FL_W-1:0]    w_flush_next;

    logic               w_wrap;
    logic               w_pk_enable;
    logic               w_pk_discard;
    logic               w_pk_take;
    logic               w_pk_complete;
    logic [BIT_SYM-1:0] w_pk_symbol;

    assign w_wrap      = (r_state != IDLE) && (r_count == CNT_LAST);
    assign w_pk_enable = (r_state == RUN);

    qpsk_bit_packer #(
        .BIT_SYM (BIT_SYM)
    ) u_packer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (w_pk_enable),
        .i_discard  (w_pk_discard),
        .i_take     (w_pk_take),
        .i_bit      (i_bit_in),
        .i_valid    (i_bit_valid),
        .o_ready    (o_bit_ready),
        .o_complete (w_pk_complete),
        .o_symbol   (w_pk_symbol)
    );

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_symbol_next    = r_symbol;
        w_strobe_next    = 1'b0;
        w_underflow_next = r_underflow;
        w_done_next      = 1'b0;
        w_stop_next      = r_stop_latch;
        w_flush_next     = r_flush_cnt;
        w_pk_discard     = 1'b0;
        w_pk_take        = 1'b0;

        case (r_state)
            IDLE: begin
                w_count_next = '0;
                if (i_start) begin
                    w_state_next     = RUN;
                    w_underflow_next = 1'b0;
                end
            end
            RUN: begin
                w_count_next = r_count + CNT_W'(1);
                if (i_stop) begin
                    w_stop_next = 1'b1;
                end
                if (w_wrap) begin
                    w_strobe_next = 1'b1;
                    if (r_stop_latch) begin
                        // This boundary is already flush symbol 1.
                        w_state_next  = FLUSH;
                        w_stop_next   = 1'b0;
                        w_pk_discard  = 1'b1;
                        w_symbol_next = IDLE_SYM;
                        w_flush_next  = FL_W'(1);
                    end else begin
                        w_pk_take = 1'b1;
                        if (w_pk_complete) begin
                            w_symbol_next = w_pk_symbol;
                        end else begin
                            w_symbol_next    = IDLE_SYM;
                            w_underflow_next = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                w_count_next = r_count + CNT_W'(1);
                if (w_wrap) begin
                    if (r_flush_cnt == FL_W'(FLUSH_SYM)) begin
                        w_state_next = IDLE;
                        w_count_next = '0;
                        w_done_next  = 1'b1;
                        w_flush_next = '0;
                    end else begin
                        w_symbol_next = IDLE_SYM;
                        w_flush_next  = r_flush_cnt + FL_W'(1);
                        w_strobe_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_symbol     <= IDLE_SYM;
            r_sym_strobe <= 1'b0;
            r_underflow  <= 1'b0;
            r_done       <= 1'b0;
            r_stop_latch <= 1'b0;
            r_flush_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_symbol     <= w_symbol_next;
            r_sym_strobe <= w_strobe_next;
            r_underflow  <= w_underflow_next;
            r_done       <= w_done_next;
            r_stop_latch <= w_stop_next;
            r_flush_cnt  <= w_flush_next;
        end
    end

    assign o_count      = r_count;
    assign o_symbol     = r_symbol;
    assign o_sym_strobe = r_sym_strobe;
    assign o_busy       = (r_state != IDLE);
    assign o_underflow  = r_underflow;
    assign o_done       = r_done;

endmodule

// File: tb/tb_qpsk_tx_sequencer.sv
// Scoreboard bench for qpsk_tx_sequencer: directed stimulus pushes expected
// strobes/done pulses; a negedge monitor pops and compares them.
module tb_qpsk_tx_sequencer;
    import qpsk_tx_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [2:0] count;
    logic [1:0] symbol;
    logic       sym_strobe;
    logic       busy;
    logic       underflow;
    logic       done;

    qpsk_tx_sequencer #(
        .SPS     (8),
        .SPAN    (16),
        .BIT_SYM (2)
    ) dut (
        .i_clock      (clk),
        .i_reset      (reset_n),
        .i_start      (start),
        .i_stop       (stop),
        .i_bit_in     (bit_in),
        .i_bit_valid  (bit_valid),
        .o_bit_ready  (bit_ready),
        .o_count      (count),
        .o_symbol     (symbol),
        .o_sym_strobe (sym_strobe),
        .o_busy       (busy),
        .o_underflow  (underflow),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [1:0] sym;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    exp_t mon_e;
    int   mon_d;
    int   total = 0;
    int   bad = 0;
    int   p, q, r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_sym(input int c, input logic [1:0] s);
        exp_t e;
        e.c   = c;
        e.sym = s;
        exp_q.push_back(e);
    endtask

    task automatic push_flush(input int first);
        for (int k = 0; k < 17; k++) push_sym(first + 8 * k, 2'b00);
    endtask

    // Monitor: every strobe and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (sym_strobe === 1'b1) begin
            $display("strobe cyc=%0d sym=%b count=%0d underflow=%b", cyc, symbol, count, underflow);
            chk("strobe_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("strobe_cycle", 32'(cyc), 32'(mon_e.c));
                chk("strobe_symbol", 32'(symbol), 32'(mon_e.sym));
                chk("strobe_count", 32'(count), 32'd0);
            end
        end
        if (done === 1'b1) begin
            $display("done cyc=%0d busy=%b", cyc, busy);
            chk("done_pending", 32'(done_q.size() > 0), 32'd1);
            if (done_q.size() > 0) begin
                mon_d = done_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(mon_d));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;

        goto(3); #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_symbol", 32'(symbol), 32'd0);
        chk("rst_strobe", 32'(sym_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(bit_ready), 32'd0);
        goto(4);
        reset_n = 1'b1;

        // Normal run, bypass, ignored controls, stop and full flush.
        p = cyc + 3;
        push_sym(p + 8, iq_pack(1'b1, 1'b0));
        push_sym(p + 16, iq_pack(1'b0, 1'b1));
        push_sym(p + 24, iq_pack(1'b1, 1'b1));
        push_flush(p + 32);
        done_q.push_back(p + 168);

        goto(p - 1); start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        goto(p); start = 1'b0; #3;
        chk("run_count0", 32'(count), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        goto(p + 1); bit_in = 1'b0;
        goto(p + 2); bit_in = 1'b0;
        goto(p + 3); #3;
        chk("full_ready_low", 32'(bit_ready), 32'd0);
        chk("run_count3", 32'(count), 32'd3);
        goto(p + 8); #3;
        chk("ready_after_load", 32'(bit_ready), 32'd1);
        goto(p + 9); bit_in = 1'b1;
        goto(p + 10); bit_valid = 1'b0;
        goto(p + 12); start = 1'b1;
        goto(p + 13); start = 1'b0;
        goto(p + 17); bit_valid = 1'b1; bit_in = 1'b1; #3;
        chk("no_underflow", 32'(underflow), 32'd0);
        goto(p + 18); bit_valid = 1'b0;
        goto(p + 23); bit_valid = 1'b1; bit_in = 1'b1;
        goto(p + 24); bit_valid = 1'b0; #3;
        chk("bypass_ready", 32'(bit_ready), 32'd1);
        chk("bypass_no_underflow", 32'(underflow), 32'd0);
        goto(p + 25); bit_valid = 1'b1; bit_in = 1'b1;
        goto(p + 26); bit_valid = 1'b0;
        goto(p + 27); stop = 1'b1;
        goto(p + 28); stop = 1'b0;
        goto(p + 33); bit_valid = 1'b1; bit_in = 1'b1;
        goto(p + 40); #3;
        chk("flush_ready_low", 32'(bit_ready), 32'd0);
        goto(p + 41); bit_valid = 1'b0;
        goto(p + 50); start = 1'b1;
        goto(p + 51); start = 1'b0;
        goto(p + 55); stop = 1'b1;
        goto(p + 56); stop = 1'b0;
        goto(p + 167); #3;
        chk("flush_busy_end", 32'(busy), 32'd1);
        goto(p + 168); #3;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_count", 32'(count), 32'd0);
        goto(p + 170); stop = 1'b1;
        goto(p + 171); stop = 1'b0;
        goto(p + 173); #3;
        chk("idle_stop_busy", 32'(busy), 32'd0);
        chk("idle_stop_count", 32'(count), 32'd0);

        // Underflow, sticky flag, then reset in the middle of FLUSH.
        q = p + 180;
        push_sym(q + 8, 2'b00);
        push_sym(q + 16, iq_pack(1'b0, 1'b1));
        push_sym(q + 24, 2'b00);
        push_sym(q + 32, 2'b00);
        push_sym(q + 40, 2'b00);
        goto(q - 1); start = 1'b1;
        goto(q); start = 1'b0; #3;
        chk("uf_start_clear", 32'(underflow), 32'd0);
        goto(q + 8); #3;
        chk("uf_set", 32'(underflow), 32'd1);
        goto(q + 9); bit_valid = 1'b1; bit_in = 1'b0;
        goto(q + 10); bit_in = 1'b1;
        goto(q + 11); bit_valid = 1'b0;
        goto(q + 16); #3;
        chk("uf_sticky", 32'(underflow), 32'd1);
        goto(q + 18); stop = 1'b1;
        goto(q + 19); stop = 1'b0;
        goto(q + 44); reset_n = 1'b0;
        goto(q + 45); reset_n = 1'b1; #3;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_symbol", 32'(symbol), 32'd0);
        chk("mrst_strobe", 32'(sym_strobe), 32'd0);
        chk("mrst_underflow", 32'(underflow), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_ready", 32'(bit_ready), 32'd0);

        // Fresh run after reset.
        r = q + 50;
        push_sym(r + 8, iq_pack(1'b1, 1'b1));
        push_flush(r + 16);
        done_q.push_back(r + 152);
        goto(r - 1); start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        goto(r); start = 1'b0; #3;
        chk("fresh_count0", 32'(count), 32'd0);
        chk("fresh_underflow", 32'(underflow), 32'd0);
        goto(r + 2); bit_valid = 1'b0;
        goto(r + 9); stop = 1'b1;
        goto(r + 10); stop = 1'b0;
        goto(r + 155); #3;
        chk("fresh_idle_busy", 32'(busy), 32'd0);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
